// File: rtl/lu_sweep_pkg.sv
// Shared definitions for the logical-unit sweep checker.
//   state_t : sweep FSM states
//   IDX_W   : width of the truth-table index {a,b}
//   CNT_W   : width of the settle counter (SETTLE range 0..15)
package lu_sweep_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned N_IDX = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/lu_sweep_checker.sv
// Sweeps a downstream 2-input logical unit through all four operand pairs
// for an accepted truth-table word, captures each result and reports whether
// the unit reproduced the word.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_valid/ready/func : truth-table word handshake (bit index = {a,b})
//   lu_a, lu_b, lu_func  : operands and word driven to the unit
//   lu_out               : combinational result from the unit
//   res_valid/ready      : result handshake
//   res_data, res_match  : captured results and equality with lu_func
//   err_clr, err_count   : saturating count of mismatching sweeps
module lu_sweep_checker
  import lu_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [3:0]       cfg_func,
  output logic             cfg_ready,
  output logic             lu_a,
  output logic             lu_b,
  output logic [3:0]       lu_func,
  input  logic             lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_match,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       res_data_nx;
  logic             accept;
  logic             settled;
  logic             last;
  logic             done;

  assign accept  = (state == ST_IDLE) && cfg_valid && cfg_ready;
  assign settled = (state == ST_DRIVE) && (cnt == CNT_W'(SETTLE));
  assign last    = settled && (idx == IDX_W'(N_IDX - 1));
  assign done    = (state == ST_REPORT) && res_ready;

  // Result vector with the current operand pair's answer merged in.
  always_comb begin
    res_data_nx      = res_data;
    res_data_nx[idx] = lu_out;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_DRIVE;
      ST_DRIVE:  if (last)   state_nx = ST_REPORT;
      ST_REPORT: if (done)   state_nx = ST_IDLE;
      default:               state_nx = ST_IDLE;
    endcase
  end

  // Sweep datapath: operands, settle counter, captured results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      lu_a      <= 1'b0;
      lu_b      <= 1'b0;
      lu_func   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_match <= 1'b0;
    end else begin
      // Ready only while the FSM will sit in IDLE for the coming cycle.
      cfg_ready <= (state_nx == ST_IDLE);
      if (accept) begin
        lu_func     <= cfg_func;
        idx         <= '0;
        cnt         <= '0;
        {lu_a, lu_b} <= 2'b00;
        res_data    <= '0;
      end else if (state == ST_DRIVE) begin
        if (settled) begin
          res_data <= res_data_nx;
          cnt      <= '0;
          if (last) begin
            res_valid <= 1'b1;
            res_match <= (res_data_nx == lu_func);
          end else begin
            idx          <= idx + IDX_W'(1);
            {lu_a, lu_b} <= idx + IDX_W'(1);
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (done) begin
        res_valid    <= 1'b0;
        idx          <= '0;
        {lu_a, lu_b} <= 2'b00;
      end
    end
  end

  // Mismatch counter; clear has priority over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (done && !res_match && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_lu_sweep_checker.sv
// Bench: unit 0 is a default checker (SETTLE=1, ERR_W=8), unit 1 uses
// SETTLE=0, ERR_W=2. Each is paired with a behavioural logical unit that can
// be correct, stuck at 0, or corrupted by a per-index flip mask.
module tb_lu_sweep_checker;

  localparam int PER  = 10;
  localparam int HALF = 5;

  typedef struct {
    int         u;
    logic [3:0] func;
    logic [3:0] data;
    bit         match;
    longint     t;
  } exp_t;

  logic       clk;
  logic       rst_n     [2];
  logic       cfg_valid [2];
  logic [3:0] cfg_func  [2];
  logic       cfg_ready [2];
  logic       lu_a      [2];
  logic       lu_b      [2];
  logic [3:0] lu_func   [2];
  logic       lu_out    [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [3:0] res_data  [2];
  logic       res_match [2];
  logic       err_clr   [2];
  logic [7:0] err0;
  logic [1:0] err1;
  int         errc      [2];

  int         mode [2];
  logic [3:0] flip [2];
  int         sp   [2] = '{2, 1};
  int         maxv [2] = '{255, 3};

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur      [2];
  bit   have     [2];
  bit   prev_v   [2];
  bit   after_hs [2];
  int   model_err[2];
  int   hs_cnt   [2];
  int   mon_qi;
  int   mon_k;

  lu_sweep_checker #(.SETTLE(1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cfg_valid(cfg_valid[0]), .cfg_func(cfg_func[0]),
    .cfg_ready(cfg_ready[0]), .lu_a(lu_a[0]), .lu_b(lu_b[0]), .lu_func(lu_func[0]),
    .lu_out(lu_out[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_data(res_data[0]), .res_match(res_match[0]), .err_clr(err_clr[0]),
    .err_count(err0)
  );

  lu_sweep_checker #(.SETTLE(0), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cfg_valid(cfg_valid[1]), .cfg_func(cfg_func[1]),
    .cfg_ready(cfg_ready[1]), .lu_a(lu_a[1]), .lu_b(lu_b[1]), .lu_func(lu_func[1]),
    .lu_out(lu_out[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_data(res_data[1]), .res_match(res_match[1]), .err_clr(err_clr[1]),
    .err_count(err1)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  always_comb begin
    errc[0] = int'(err0);
    errc[1] = int'(err1);
  end

  // Downstream logical units: correct, stuck-at-0, or flipped per index.
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      if (mode[u] == 1)
        lu_out[u] = 1'b0;
      else
        lu_out[u] = lu_func[u][{lu_a[u], lu_b[u]}]
                    ^ ((mode[u] == 2) && flip[u][{lu_a[u], lu_b[u]}]);
    end
  end

  function automatic void check(input string name, input int u, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s unit%0d t=%0t got=%0d expected=%0d", name, u, $time, act, exp);
    end
  endfunction

  // Expected result of a sweep, derived from how the unit is configured.
  function automatic logic [3:0] unit_result(input int m, input logic [3:0] f, input logic [3:0] fl);
    if (m == 1) return 4'b0000;
    if (m == 2) return f ^ fl;
    return f;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n[u]) begin
        have[u] = 0; prev_v[u] = 0; after_hs[u] = 0; model_err[u] = 0;
        for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].u == u) sb.delete(k);
      end else begin
        check("err_count", u, errc[u], model_err[u]);
        if (after_hs[u]) begin
          check("idle_res_valid", u, int'(res_valid[u]), 0);
          check("idle_ab", u, int'({lu_a[u], lu_b[u]}), 0);
          check("idle_cfg_ready", u, int'(cfg_ready[u]), 1);
          after_hs[u] = 0;
        end
        mon_qi = -1;
        foreach (sb[k]) if (mon_qi < 0 && sb[k].u == u) mon_qi = k;
        if (res_valid[u] && !prev_v[u]) begin
          if (mon_qi < 0) begin
            check("unexpected_result", u, 1, 0);
          end else begin
            cur[u] = sb[mon_qi];
            sb.delete(mon_qi);
            have[u] = 1;
            mon_k = int'((longint'($time) - cur[u].t - HALF) / PER);
            check("latency", u, mon_k, 4 * sp[u]);
            check("res_data", u, int'(res_data[u]), int'(cur[u].data));
            check("res_match", u, int'(res_match[u]), int'(cur[u].match));
            check("report_cfg_ready", u, int'(cfg_ready[u]), 0);
          end
        end else if (res_valid[u] && have[u]) begin
          check("hold_res_data", u, int'(res_data[u]), int'(cur[u].data));
          check("hold_res_match", u, int'(res_match[u]), int'(cur[u].match));
          check("hold_ab", u, int'({lu_a[u], lu_b[u]}), 3);
          check("hold_lu_func", u, int'(lu_func[u]), int'(cur[u].func));
          check("report_cfg_ready", u, int'(cfg_ready[u]), 0);
        end else if (!res_valid[u] && mon_qi >= 0) begin
          mon_k = int'((longint'($time) - sb[mon_qi].t - HALF) / PER);
          if (mon_k < 4 * sp[u]) begin
            check("drive_ab", u, int'({lu_a[u], lu_b[u]}), mon_k / sp[u]);
            check("drive_lu_func", u, int'(lu_func[u]), int'(sb[mon_qi].func));
            check("drive_cfg_ready", u, int'(cfg_ready[u]), 0);
          end
        end
        // Counter behaviour on the coming edge.
        if (err_clr[u])
          model_err[u] = 0;
        else if (res_valid[u] && res_ready[u] && have[u] && !cur[u].match
                 && model_err[u] < maxv[u])
          model_err[u]++;
        if (res_valid[u] && res_ready[u]) begin
          hs_cnt[u]++;
          after_hs[u] = 1;
          have[u] = 0;
        end
        prev_v[u] = res_valid[u];
      end
    end
  end

  task automatic chk_reset(input int u);
    check("rst_cfg_ready", u, int'(cfg_ready[u]), 0);
    check("rst_ab", u, int'({lu_a[u], lu_b[u]}), 0);
    check("rst_lu_func", u, int'(lu_func[u]), 0);
    check("rst_res_valid", u, int'(res_valid[u]), 0);
    check("rst_res_data", u, int'(res_data[u]), 0);
    check("rst_res_match", u, int'(res_match[u]), 0);
    check("rst_err_count", u, errc[u], 0);
  endtask

  // Issue one word and see its result consumed. hold keeps res_ready low for
  // five REPORT cycles while a stray cfg_valid is offered; clr raises err_clr
  // on the handshake edge.
  task automatic run_word(input int u, input logic [3:0] f, input int m,
                          input logic [3:0] fl, input bit hold, input bit clr);
    int   n;
    int   hs0;
    exp_t e;
    mode[u] = m;
    flip[u] = fl;
    cfg_func[u]  = f;
    cfg_valid[u] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cfg_ready[u] && n < 50);
    if (!cfg_ready[u]) begin
      check("accept_timeout", u, 0, 1);
      cfg_valid[u] = 1'b0;
      return;
    end
    @(posedge clk);
    e.u = u; e.func = f; e.data = unit_result(m, f, fl);
    e.match = (e.data == f); e.t = longint'($time);
    sb.push_back(e);
    #1 cfg_valid[u] = 1'b0;
    hs0 = hs_cnt[u];
    n = 0;
    if (hold) begin
      res_ready[u] = 1'b0;
      while (!res_valid[u] && n < 200) begin @(posedge clk); #1; n++; end
      if (!res_valid[u]) begin
        check("result_timeout", u, 0, 1);
        return;
      end
      for (int i = 0; i < 5; i++) begin
        cfg_valid[u] = (i == 1);
        cfg_func[u]  = ~f;
        @(posedge clk); #1;
      end
      cfg_valid[u] = 1'b0;
      err_clr[u]   = clr;
    end
    while (hs_cnt[u] == hs0 && n < 300) begin
      res_ready[u] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    res_ready[u] = 1'b0;
    err_clr[u]   = 1'b0;
    if (hs_cnt[u] == hs0) check("handshake_timeout", u, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; cfg_valid[u] = 1'b0; cfg_func[u] = '0; res_ready[u] = 1'b0;
      err_clr[u] = 1'b0; mode[u] = 0; flip[u] = '0; hs_cnt[u] = 0; model_err[u] = 0;
      have[u] = 0; prev_v[u] = 0; after_hs[u] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    check("cfg_ready_pre_edge", 0, int'(cfg_ready[0]), 0);
    @(posedge clk); #1;
    check("cfg_ready_post_edge", 0, int'(cfg_ready[0]), 1);
    check("cfg_ready_post_edge", 1, int'(cfg_ready[1]), 1);

    // Correct XOR unit.
    run_word(0, 4'b0110, 0, 4'b0000, 0, 0);
    check("err_after_match", 0, errc[0], 0);
    // Unit stuck at 0.
    run_word(0, 4'b1000, 1, 4'b0000, 0, 0);
    check("err_after_mismatch", 0, errc[0], 1);
    // Result held under back-pressure with a stray word offered.
    run_word(0, 4'b1010, 0, 4'b0000, 1, 0);
    // Randomized words and unit behaviours.
    for (int i = 0; i < 10; i++)
      run_word(0, 4'($urandom), int'($urandom_range(0, 2)), 4'($urandom), 0, 0);

    // Reset while driving index 2.
    mode[0] = 0;
    cfg_func[0]  = 4'b0101;
    cfg_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cfg_ready[0] && n < 50);
    @(posedge clk); #1 cfg_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_sweep_ab", 0, int'({lu_a[0], lu_b[0]}), 2);
    rst_n[0] = 1'b0;
    #1;
    chk_reset(0);
    @(posedge clk); #2;
    rst_n[0] = 1'b1;
    #1;
    check("cfg_ready_pre_edge", 0, int'(cfg_ready[0]), 0);
    @(posedge clk); #1;
    check("cfg_ready_post_edge", 0, int'(cfg_ready[0]), 1);
    run_word(0, 4'b1111, 0, 4'b0000, 0, 0);

    // SETTLE=0, ERR_W=2 instance.
    run_word(1, 4'b0110, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++)
      run_word(1, 4'b1000 | 4'($urandom_range(0, 7)), 1, 4'b0000, 0, 0);
    check("err_saturated", 1, errc[1], 3);
    run_word(1, 4'b0100, 1, 4'b0000, 1, 1);
    check("err_clear_wins", 1, errc[1], 0);
    for (int i = 0; i < 6; i++)
      run_word(1, 4'($urandom), int'($urandom_range(0, 2)), 4'($urandom), 0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lu_sweep_checker.md
LU_SWEEP_CHECKER -- requirements
Module: lu_sweep_checker

Interface
REQ-001 Parameter: SETTLE, default 1, cycles waited after driving each operand pair before sampling lu_out (legal 0..15).
REQ-002 Parameter: ERR_W, default 8, width of the mismatch counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cfg_valid  in  1  truth-table word offered.
REQ-007 cfg_func  in  4  truth-table word; bit index = {a,b}.
REQ-008 cfg_ready  out  1  block accepts a word this cycle.
REQ-009 lu_a, lu_b  out  1 each  operands driven to the downstream logical unit.
REQ-010 lu_func  out  4  latched truth-table word driven to the logical unit.
REQ-011 lu_out  in  1  combinational result returned from the logical unit.
REQ-012 res_valid  out  1  sweep result available.
REQ-013 res_ready  in  1  consumer accepts the result.
REQ-014 res_data  out  4  captured lu_out per index {a,b}.
REQ-015 res_match  out  1  res_data equals lu_func.
REQ-016 err_clr  in  1  synchronous clear of err_count.
REQ-017 err_count  out  ERR_W  saturating count of mismatching sweeps.

Function
REQ-018 The FSM SHALL have states IDLE, DRIVE, REPORT; cfg_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, on a clock edge with cfg_valid=1 and cfg_ready=1, the block SHALL latch cfg_func into lu_func, set idx=0, cnt=0 and enter DRIVE.
REQ-020 In DRIVE, {lu_a,lu_b} SHALL equal idx (2-bit) and cnt SHALL increment each cycle.
REQ-021 On the edge where cnt==SETTLE, the block SHALL store lu_out into res_data[idx] and clear cnt; if idx==3 it SHALL enter REPORT, otherwise increment idx.
REQ-022 Each index SHALL therefore occupy SETTLE+1 cycles; res_valid SHALL rise 4*(SETTLE+1) cycles after the accept edge (8 at default).
REQ-023 In REPORT, res_valid=1 and res_data, res_match, lu_a, lu_b, lu_func SHALL hold stable until the edge with res_ready=1, then return to IDLE (one-cycle bubble before the next accept).
REQ-024 res_ready while res_valid=0 SHALL have no effect; cfg_valid outside IDLE SHALL be ignored, no word lost or queued.
REQ-025 res_match SHALL be computed from the complete res_data and be valid whenever res_valid=1.
REQ-026 On the REPORT handshake edge with res_match=0, err_count SHALL increment, saturating at 2^ERR_W-1.
REQ-027 err_clr=1 SHALL clear err_count to 0 on the next edge; simultaneous with an increment, clear SHALL win.
REQ-028 lu_a, lu_b SHALL be 0 in IDLE; lu_func SHALL retain the last word.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, idx=0, cnt=0, cfg_ready=0, lu_a=0, lu_b=0, lu_func=0, res_valid=0, res_data=0, res_match=0, err_count=0.
REQ-030 cfg_ready SHALL be registered and rise on the first clock edge after rst_n deasserts.
REQ-031 Reset mid-sweep or mid-REPORT SHALL discard the in-flight word with no partial result emitted.

Structure
REQ-032 Package lu_sweep_pkg SHALL hold the state enum, the idx width (2) and the SETTLE counter width (4).
REQ-033 The block SHALL be a single module with no sub-modules; the bench pairs it with the downstream logical unit.

Verification
REQ-034 Reset, correct XOR unit, cfg_func=4'b0110 -> {lu_a,lu_b} steps 00,01,10,11 two cycles each; res_valid 8 cycles after accept; res_data=0110, res_match=1, err_count=0.
REQ-035 lu_out forced 0, cfg_func=4'b1000 -> res_data=0000, res_match=0, err_count=1 after handshake.
REQ-036 res_ready low 5 cycles in REPORT, cfg_valid pulsed -> res_valid/res_data stable, cfg_ready=0, no word accepted; handshake then IDLE.
REQ-037 rst_n pulsed low during DRIVE idx=2 -> all outputs 0 immediately; after release cfg_ready=1 next edge and a fresh word 4'b1111 sweeps to res_data=1111.
REQ-038 ERR_W=2, four mismatching sweeps -> err_count=3 (saturated); err_clr on the fifth mismatch handshake -> err_count=0.
REQ-039 SETTLE=0 -> each index one cycle; res_valid 4 cycles after accept.
